// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch direction predictor: saturating-counter table swept to
// weakly-not-taken after reset, zero-latency lookup, execute-side training and GHR repair.
module branch_predictor_gshare #(
   parameter int INDEX_WIDTH = 8,
   parameter int CTR_WIDTH   = 2,
   parameter int GHR_WIDTH   = 8,
   parameter int MODE        = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 o_ready,
   input  logic                 i_req_valid,
   input  logic [31:0]          i_req_pc,
   output logic                 o_req_prediction,
   output logic [GHR_WIDTH-1:0] o_req_ghr,
   input  logic                 i_fb_valid,
   input  logic [31:0]          i_fb_pc,
   input  logic [GHR_WIDTH-1:0] i_fb_ghr,
   input  logic                 i_fb_prediction,
   input  logic                 i_fb_outcome,
   output logic [31:0]          o_fb_count,
   output logic [31:0]          o_mispredict_count
);
   localparam int ENTRIES = 1 << INDEX_WIDTH;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_MAX >> 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t                 state;
   logic [INDEX_WIDTH-1:0] ptr;
   logic [GHR_WIDTH-1:0]   ghr;
   logic [CTR_WIDTH-1:0]   ctr_tbl [ENTRIES];

   logic [INDEX_WIDTH-1:0] req_idx, fb_idx;
   logic [CTR_WIDTH-1:0]   req_ctr, fb_cur, fb_next;
   logic                   fb_acc, mispredict;
   logic                   unused_pc_bits;

   function automatic logic [INDEX_WIDTH-1:0] idx(input logic [31:0] pc,
                                                  input logic [GHR_WIDTH-1:0] h);
      if (MODE != 0) return pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(h);
      return pc[INDEX_WIDTH+1:2];
   endfunction

   // Append one outcome bit; the {h, b} form also covers GHR_WIDTH = 1.
   function automatic logic [GHR_WIDTH-1:0] shift_in(input logic [GHR_WIDTH-1:0] h,
                                                      input logic b);
      logic [GHR_WIDTH:0] t;
      t = {h, b};
      return t[GHR_WIDTH-1:0];
   endfunction

   assign unused_pc_bits = ^{i_req_pc[31:INDEX_WIDTH+2], i_req_pc[1:0],
                             i_fb_pc[31:INDEX_WIDTH+2], i_fb_pc[1:0]};

   assign req_idx          = idx(i_req_pc, ghr);
   assign fb_idx           = idx(i_fb_pc, i_fb_ghr);
   assign req_ctr          = ctr_tbl[req_idx];
   assign o_req_prediction = (state == RUN) && req_ctr[CTR_WIDTH-1];
   assign o_req_ghr        = ghr;
   assign fb_acc           = (state == RUN) && i_fb_valid;
   assign mispredict       = fb_acc && (i_fb_prediction != i_fb_outcome);

   always_comb begin
      fb_cur  = ctr_tbl[fb_idx];
      fb_next = fb_cur;
      if (i_fb_outcome) begin
         if (fb_cur != CTR_MAX) fb_next = fb_cur + 1'b1;
      end else if (fb_cur != '0) begin
         fb_next = fb_cur - 1'b1;
      end
   end

   // Table is plain storage: the INIT sweep, not reset, gives it defined contents.
   always_ff @(posedge clk) begin
      if (state == INIT)  ctr_tbl[ptr]    <= CTR_WNT;
      else if (fb_acc)    ctr_tbl[fb_idx] <= fb_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= INIT;
         ptr                <= '0;
         ghr                <= '0;
         o_ready            <= 1'b0;
         o_fb_count         <= '0;
         o_mispredict_count <= '0;
      end else begin
         case (state)
            INIT: begin
               ptr <= ptr + 1'b1;
               if (ptr == '1) begin
                  state   <= RUN;
                  o_ready <= 1'b1;
               end
            end
            RUN: begin
               if (fb_acc)     o_fb_count         <= o_fb_count + 32'd1;
               if (mispredict) o_mispredict_count <= o_mispredict_count + 32'd1;
               // A same-cycle request is wrong-path when the repair fires.
               if (mispredict)       ghr <= shift_in(i_fb_ghr, i_fb_outcome);
               else if (i_req_valid) ghr <= shift_in(ghr, o_req_prediction);
            end
            default: state <= INIT;
         endcase
      end
   end
endmodule
